// File: rtl/seq_div_32_pkg.sv
// Shared widths and state encoding for the sequential divider slice.
// Widths that the legacy shared header provided are defined here as constants.
package seq_div_32_pkg;

   localparam int unsigned DATA_INDEX_LIMIT = 31;
   localparam int unsigned DATA_WIDTH       = DATA_INDEX_LIMIT + 1;
   // One quotient bit is produced per RUN cycle, so the iteration count is the width.
   localparam int unsigned DIV_ITER_COUNT   = DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } divStateT;

endpackage

// File: rtl/seq_div_32_rc_add_sub.sv
// Ripple-carry adder/subtractor: Y = A + B when SnA=0, Y = A - B when SnA=1.
// With SnA=1, CO=1 means no borrow occurred (A >= B).
module RC_ADD_SUB_32
   import seq_div_32_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_WIDTH
) (
   output logic [WIDTH-1:0] Y,
   output logic             CO,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             SnA
);

   logic [WIDTH-1:0] bOp;
   logic [WIDTH:0]   carry;

   always_comb begin
      bOp      = B ^ {WIDTH{SnA}};
      carry    = '0;
      carry[0] = SnA;
      Y        = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         Y[i]       = A[i] ^ bOp[i] ^ carry[i];
         carry[i+1] = (A[i] & bOp[i]) | (carry[i] & (A[i] ^ bOp[i]));
      end
      CO = carry[WIDTH];
   end

endmodule

// File: rtl/seq_div_32.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Define SEQ_DIV_SIGNED_EN to add the SnU port and two's-complement division.
module seq_div_32
   import seq_div_32_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_INDEX_LIMIT + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
`ifdef SEQ_DIV_SIGNED_EN
   input  logic             SnU,
`endif
   input  logic [WIDTH-1:0] DVD,
   input  logic [WIDTH-1:0] DVR,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             BUSY,
   output logic             DONE,
   output logic             DIV0
);

   localparam int unsigned     CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

   divStateT         state, nextState;
   logic             accept, dvrZero, lastIter, co, notBorrow;
   logic [CW-1:0]    iterCnt;
   logic [WIDTH-1:0] dvdSh, remReg, dvrReg;
   logic [WIDTH-1:0] shifted, diff, nextRem, nextDvdSh;
   logic [WIDTH-1:0] dvdMag, dvrMag, qFinal, rFinal;

   // The bit shifted out of the partial remainder makes it exceed any divisor,
   // so it forces a successful subtract even when the narrow adder borrows.
   assign shifted   = {remReg[WIDTH-2:0], dvdSh[WIDTH-1]};
   assign notBorrow = co | remReg[WIDTH-1];
   assign nextRem   = notBorrow ? diff : shifted;
   assign nextDvdSh = {dvdSh[WIDTH-2:0], notBorrow};
   assign dvrZero   = (DVR == '0);
   assign lastIter  = (iterCnt == LAST_CNT);

   RC_ADD_SUB_32 #(.WIDTH(WIDTH)) uTrialSub (
      .Y   (diff),
      .CO  (co),
      .A   (shifted),
      .B   (dvrReg),
      .SnA (1'b1)
   );

`ifdef SEQ_DIV_SIGNED_EN
   logic dvdNeg, dvrNeg, qNegR, rNegR;

   assign dvdNeg = SnU & DVD[WIDTH-1];
   assign dvrNeg = SnU & DVR[WIDTH-1];
   assign dvdMag = dvdNeg ? -DVD : DVD;
   assign dvrMag = dvrNeg ? -DVR : DVR;
   assign qFinal = qNegR ? -nextDvdSh : nextDvdSh;
   assign rFinal = rNegR ? -nextRem : nextRem;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         qNegR <= 1'b0;
         rNegR <= 1'b0;
      end else if (accept) begin
         qNegR <= dvdNeg ^ dvrNeg;
         rNegR <= dvdNeg;
      end
   end
`else
   assign dvdMag = DVD;
   assign dvrMag = DVR;
   assign qFinal = nextDvdSh;
   assign rFinal = nextRem;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      accept    = 1'b0;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      unique case (state)
         IDLE, FIN: begin
            DONE = (state == FIN);
            if (START) begin
               accept    = 1'b1;
               nextState = dvrZero ? FIN : RUN;
            end else begin
               nextState = IDLE;
            end
         end
         RUN: begin
            BUSY = 1'b1;
            if (lastIter) nextState = FIN;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         iterCnt <= '0;
         dvdSh   <= '0;
         remReg  <= '0;
         dvrReg  <= '0;
         Q       <= '0;
         R       <= '0;
         DIV0    <= 1'b0;
      end else if (accept) begin
         iterCnt <= '0;
         dvdSh   <= dvdMag;
         remReg  <= '0;
         dvrReg  <= dvrMag;
         DIV0    <= dvrZero;
         if (dvrZero) begin
            Q <= '1;
            R <= DVD;
         end
      end else if (state == RUN) begin
         iterCnt <= iterCnt + CW'(1);
         dvdSh   <= nextDvdSh;
         remReg  <= nextRem;
         if (lastIter) begin
            Q <= qFinal;
            R <= rFinal;
         end
      end
   end

endmodule

// File: tb/tb_seq_div_32.sv
// Self-checking bench for seq_div_32: scoreboard of expected results from an
// arithmetic model, checked for value and latency whenever DONE pulses.
module tb_seq_div_32;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        div0;
      int          lat;
   } expT;

   logic        CLK = 1'b0;
   logic        RST, START, SnU;
   logic [31:0] DVD, DVR;
   logic [31:0] Q, R;
   logic        BUSY, DONE, DIV0;

   expT         sb[$];
   int          nTests = 0;
   int          nFail  = 0;
   logic [31:0] expQ = '0;
   logic [31:0] expR = '0;

   always #5 CLK = ~CLK;

   seq_div_32 #(.WIDTH(32)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
`ifdef SEQ_DIV_SIGNED_EN
      .SnU   (SnU),
`endif
      .DVD   (DVD),
      .DVR   (DVR),
      .Q     (Q),
      .R     (R),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .DIV0  (DIV0)
   );

   function automatic expT model(input logic [31:0] a, input logic [31:0] b, input logic s);
      expT    e;
      longint sa, sbv;
      if (b == 32'd0) begin
         e.q = '1; e.r = a; e.div0 = 1'b1; e.lat = 1;
      end else if (s) begin
         sa  = longint'($signed(a));
         sbv = longint'($signed(b));
         e.q = 32'(sa / sbv); e.r = 32'(sa % sbv); e.div0 = 1'b0; e.lat = 33;
      end else begin
         e.q = a / b; e.r = a % b; e.div0 = 1'b0; e.lat = 33;
      end
      return e;
   endfunction

   task automatic pulseStart(input logic [31:0] a, input logic [31:0] b);
      DVD   = a;
      DVR   = b;
      START = 1'b1;
      sb.push_back(model(a, b, SnU));
      @(posedge CLK);
      #1 START = 1'b0;
   endtask

   task automatic waitDone(input int maxN, output int n);
      n = -1;
      for (int i = 1; i <= maxN; i++) begin
         @(negedge CLK);
         if (DONE === 1'b1) begin
            n = i;
            return;
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; START = 1'b0; SnU = 1'b0; DVD = '0; DVR = '0;
      repeat (3) @(negedge CLK);
      nTests++; if (Q !== 32'd0)  begin nFail++; $display("FAIL reset_q: got %h expected 0", Q); end
      nTests++; if (R !== 32'd0)  begin nFail++; $display("FAIL reset_r: got %h expected 0", R); end
      nTests++; if (BUSY !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
      nTests++; if (DONE !== 1'b0) begin nFail++; $display("FAIL reset_done: got %b expected 0", DONE); end
      nTests++; if (DIV0 !== 1'b0) begin nFail++; $display("FAIL reset_div0: got %b expected 0", DIV0); end
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_unsigned();
      expT e; int n; bit busyBad, holdBad;
      pulseStart(32'd100, 32'd7);
      n = -1; busyBad = 0; holdBad = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge CLK);
         if (DONE === 1'b1) begin n = i; break; end
         if (BUSY !== 1'b1) busyBad = 1;
         if (Q !== expQ || R !== expR) holdBad = 1;
      end
      e = sb.pop_front(); expQ = e.q; expR = e.r;
      nTests++; if (n !== e.lat) begin nFail++; $display("FAIL unsigned_latency: got %0d expected %0d", n, e.lat); end
      nTests++; if (busyBad) begin nFail++; $display("FAIL unsigned_busy_run: got low expected high"); end
      nTests++; if (holdBad) begin nFail++; $display("FAIL unsigned_hold: Q/R changed during RUN expected %h/%h", expQ, expR); end
      nTests++; if (BUSY !== 1'b0) begin nFail++; $display("FAIL unsigned_busy_fin: got %b expected 0", BUSY); end
      nTests++; if (Q !== e.q) begin nFail++; $display("FAIL unsigned_q: got %h expected %h", Q, e.q); end
      nTests++; if (R !== e.r) begin nFail++; $display("FAIL unsigned_r: got %h expected %h", R, e.r); end
      nTests++; if (DIV0 !== e.div0) begin nFail++; $display("FAIL unsigned_div0: got %b expected %b", DIV0, e.div0); end
      @(negedge CLK);
      nTests++; if (DONE !== 1'b0) begin nFail++; $display("FAIL unsigned_done_pulse: got %b expected 0", DONE); end
   endtask

   task automatic test_table();
      logic [31:0] ta [4] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [31:0] tv [4] = '{32'd1, 32'hFFFF_FFFF, 32'h8000_0001, 32'd2};
      logic [31:0] a, b; expT e; int n;
      for (int i = 0; i < 10; i++) begin
         if (i < 4) begin
            a = ta[i]; b = tv[i];
         end else begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 5000)) : $urandom;
         end
         pulseStart(a, b);
         waitDone(40, n);
         e = sb.pop_front(); expQ = e.q; expR = e.r;
         nTests++; if (n !== e.lat) begin nFail++; $display("FAIL table%0d_latency: got %0d expected %0d", i, n, e.lat); end
         nTests++; if (Q !== e.q) begin nFail++; $display("FAIL table%0d_q: %h/%h got %h expected %h", i, a, b, Q, e.q); end
         nTests++; if (R !== e.r) begin nFail++; $display("FAIL table%0d_r: %h/%h got %h expected %h", i, a, b, R, e.r); end
         nTests++; if (DIV0 !== e.div0) begin nFail++; $display("FAIL table%0d_div0: got %b expected %b", i, DIV0, e.div0); end
         @(negedge CLK);
      end
   endtask

   task automatic test_div0();
      expT e; int n; bit clearBad;
      pulseStart(32'd23, 32'd0);
      waitDone(40, n);
      e = sb.pop_front(); expQ = e.q; expR = e.r;
      nTests++; if (n !== 1) begin nFail++; $display("FAIL div0_latency: got %0d expected 1", n); end
      nTests++; if (DIV0 !== 1'b1) begin nFail++; $display("FAIL div0_flag: got %b expected 1", DIV0); end
      nTests++; if (Q !== 32'hFFFF_FFFF) begin nFail++; $display("FAIL div0_q: got %h expected ffffffff", Q); end
      nTests++; if (R !== 32'd23) begin nFail++; $display("FAIL div0_r: got %h expected 17", R); end
      repeat (3) @(negedge CLK);
      nTests++; if (DIV0 !== 1'b1) begin nFail++; $display("FAIL div0_held: got %b expected 1", DIV0); end
      nTests++; if (DONE !== 1'b0) begin nFail++; $display("FAIL div0_done_idle: got %b expected 0", DONE); end
      pulseStart(32'd100, 32'd7);
      @(negedge CLK);
      clearBad = (DIV0 !== 1'b0);
      nTests++; if (clearBad) begin nFail++; $display("FAIL div0_clear: got %b expected 0", DIV0); end
      waitDone(40, n);
      e = sb.pop_front(); expQ = e.q; expR = e.r;
      nTests++; if (n !== e.lat - 1) begin nFail++; $display("FAIL div0_next_latency: got %0d expected %0d", n + 1, e.lat); end
      nTests++; if (Q !== e.q || R !== e.r) begin nFail++; $display("FAIL div0_next_qr: got %h/%h expected %h/%h", Q, R, e.q, e.r); end
      @(negedge CLK);
   endtask

   task automatic test_back_to_back();
      expT e; int n; bit holdBad;
      pulseStart(32'd100, 32'd7);
      n = -1; holdBad = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge CLK);
         if (DONE === 1'b1) begin n = i; break; end
         if (Q !== expQ || R !== expR) holdBad = 1;
         if (i == 4) begin DVD = 32'd1; DVR = 32'd1; START = 1'b1; end
         if (i == 5) START = 1'b0;
      end
      e = sb.pop_front(); expQ = e.q; expR = e.r;
      nTests++; if (n !== 33) begin nFail++; $display("FAIL b2b_first_latency: got %0d expected 33", n); end
      nTests++; if (holdBad) begin nFail++; $display("FAIL b2b_hold: Q/R changed during RUN"); end
      nTests++; if (Q !== 32'd14 || R !== 32'd2) begin nFail++; $display("FAIL b2b_first_qr: got %h/%h expected 0000000e/00000002", Q, R); end
      pulseStart(32'd1000, 32'd9);
      waitDone(40, n);
      e = sb.pop_front(); expQ = e.q; expR = e.r;
      nTests++; if (n !== 33) begin nFail++; $display("FAIL b2b_second_latency: got %0d expected 33", n); end
      nTests++; if (Q !== e.q || R !== e.r) begin nFail++; $display("FAIL b2b_second_qr: got %h/%h expected %h/%h", Q, R, e.q, e.r); end
      @(negedge CLK);
   endtask

   task automatic test_reset_abort();
      expT e; int n; bit doneSeen;
      pulseStart(32'd100, 32'd7);
      repeat (10) @(negedge CLK);
      RST = 1'b1;
      #1;
      nTests++; if (Q !== 32'd0) begin nFail++; $display("FAIL abort_q: got %h expected 0", Q); end
      nTests++; if (R !== 32'd0) begin nFail++; $display("FAIL abort_r: got %h expected 0", R); end
      nTests++; if (BUSY !== 1'b0) begin nFail++; $display("FAIL abort_busy: got %b expected 0", BUSY); end
      nTests++; if (DONE !== 1'b0) begin nFail++; $display("FAIL abort_done: got %b expected 0", DONE); end
      void'(sb.pop_back());
      expQ = '0; expR = '0;
      @(negedge CLK);
      RST = 1'b0;
      doneSeen = 0;
      repeat (40) begin
         @(negedge CLK);
         if (DONE !== 1'b0) doneSeen = 1;
      end
      nTests++; if (doneSeen) begin nFail++; $display("FAIL abort_no_done: got DONE expected none"); end
      pulseStart(32'd28, 32'd3);
      waitDone(40, n);
      e = sb.pop_front(); expQ = e.q; expR = e.r;
      nTests++; if (n !== 33) begin nFail++; $display("FAIL abort_next_latency: got %0d expected 33", n); end
      nTests++; if (Q !== 32'd9 || R !== 32'd1) begin nFail++; $display("FAIL abort_next_qr: got %h/%h expected 00000009/00000001", Q, R); end
      @(negedge CLK);
   endtask

`ifdef SEQ_DIV_SIGNED_EN
   task automatic test_signed();
      logic [31:0] ta [5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FF9C, 32'd5};
      logic [31:0] tv [5] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd0};
      logic [31:0] a, b; expT e; int n;
      SnU = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i < 5) begin
            a = ta[i]; b = tv[i];
         end else begin
            a = $urandom; b = $urandom | 32'd1;
         end
         pulseStart(a, b);
         waitDone(40, n);
         e = sb.pop_front(); expQ = e.q; expR = e.r;
         nTests++; if (n !== e.lat) begin nFail++; $display("FAIL signed%0d_latency: got %0d expected %0d", i, n, e.lat); end
         nTests++; if (Q !== e.q) begin nFail++; $display("FAIL signed%0d_q: %h/%h got %h expected %h", i, a, b, Q, e.q); end
         nTests++; if (R !== e.r) begin nFail++; $display("FAIL signed%0d_r: %h/%h got %h expected %h", i, a, b, R, e.r); end
         nTests++; if (DIV0 !== e.div0) begin nFail++; $display("FAIL signed%0d_div0: got %b expected %b", i, DIV0, e.div0); end
         @(negedge CLK);
      end
      SnU = 1'b0;
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_unsigned();
      test_table();
      test_div0();
      test_back_to_back();
      test_reset_abort();
`ifdef SEQ_DIV_SIGNED_EN
      test_signed();
`endif
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/seq_div_32.md
SEQ_DIV_32 -- requirements
Module: seq_div_32

Interface
REQ-001 Parameter: WIDTH, default 32 (`DATA_INDEX_LIMIT+1), operand/result width; iteration count equals WIDTH.
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  asynchronous, active-high reset.
REQ-004 Port: START  input  1  request; sampled only in IDLE or DONE.
REQ-005 Port: DVD  input  WIDTH  dividend; captured on accepted START.
REQ-006 Port: DVR  input  WIDTH  divisor; captured on accepted START.
REQ-007 Port: Q  output  WIDTH  quotient, registered.
REQ-008 Port: R  output  WIDTH  remainder, registered.
REQ-009 Port: BUSY  output  1  high in RUN.
REQ-010 Port: DONE  output  1  one-cycle pulse when Q/R become valid.
REQ-011 Port: DIV0  output  1  divisor-zero flag, valid with DONE, held until next accepted START.

Function
REQ-012 States: IDLE, RUN, FIN; FIN lasts exactly one cycle, then IDLE.
REQ-013 Accepted START (IDLE or FIN, START=1 at edge k) captures DVD/DVR, clears DIV0, enters RUN at k+1.
REQ-014 START while in RUN is ignored; operands and progress unaffected.
REQ-015 RUN: restoring shift-subtract, one quotient bit per cycle, MSB first; trial subtract of partial remainder minus divisor; restore when borrow.
REQ-016 Iteration counter counts WIDTH cycles in RUN; terminal count moves to FIN.
REQ-017 Latency: DONE=1 in cycle k+WIDTH+1 (k+33 for WIDTH=32); Q/R valid from that cycle.
REQ-018 Q/R hold the last result until the next accepted START's result is written; not altered during RUN.
REQ-019 DVR=0: no RUN; FIN at k+1 with DONE=1, DIV0=1, Q=all ones, R=DVD.
REQ-020 DONE is low in all states except FIN; BUSY is low in IDLE and FIN.
REQ-021 Back-to-back: START=1 in FIN is accepted; the new RUN begins the next cycle.

Reset
REQ-022 RST=1 forces, asynchronously: state IDLE, counter 0, Q=0, R=0, BUSY=0, DONE=0, DIV0=0.
REQ-023 RST during RUN aborts the operation; no DONE is produced for it; first START after release behaves as from power-up.

Configuration
REQ-024 Macro SEQ_DIV_SIGNED_EN defined: extra input port SnU (1 bit, sampled with START; 1=signed two's-complement, 0=unsigned).
REQ-025 Signed mode: magnitudes divided; Q truncates toward zero, R takes the dividend's sign; same latency as unsigned.
REQ-026 Signed overflow: DVD=0x80000000, DVR=0xFFFFFFFF gives Q=0x80000000, R=0, DIV0=0.
REQ-027 Macro undefined: no SnU port; unsigned only; no sign-correction logic.

Structure
REQ-028 Widths come from prj_definition.v (`DATA_INDEX_LIMIT, `DATA_WIDTH); state encodings and the iteration-count constant live in the same shared header.
REQ-029 The trial subtraction instantiates the existing RC_ADD_SUB_32 with SnA=1; its CO serves as the not-borrow; no other sub-modules.

Verification
REQ-030 Unsigned: DVD=100, DVR=7, START at edge k -> DONE at k+33, Q=14, R=2, DIV0=0, BUSY high k+1..k+32.
REQ-031 Extremes: DVD=0xFFFFFFFF, DVR=1 -> Q=0xFFFFFFFF, R=0; then DVD=5, DVR=0xFFFFFFFF -> Q=0, R=5.
REQ-032 Divide by zero: DVD=23, DVR=0 -> DONE at k+1, DIV0=1, Q=0xFFFFFFFF, R=23.
REQ-033 Protocol: START pulsed at k+5 during RUN with DVD=1 -> ignored, first result (Q=14, R=2) unchanged; START in the FIN cycle -> new result 33 cycles later.
REQ-034 Reset: RST asserted at k+10 in RUN -> Q=0, R=0, BUSY=0 immediately, no DONE; next START DVD=28, DVR=3 -> Q=9, R=1.
REQ-035 With SEQ_DIV_SIGNED_EN, SnU=1: DVD=-7, DVR=2 -> Q=0xFFFFFFFD, R=0xFFFFFFFF; DVD=0x80000000, DVR=-1 -> Q=0x80000000, R=0.
